reg_file_wb: RTL and testbench

- 32 x 32-bit MIPS general register file with a one-entry write-back staging register.
- Sits directly downstream of the 5-bit 4:1 write-address mux.
  - That mux picks rt / rd / 31 / 0.
  - Its 5-bit output drives wa here.
- Provides two combinational read ports for decode, plus a debug read port for the display path.
- Writes are staged one cycle, committed the next, and bypassed to readers meanwhile.

---
 rtl/reg_file_wb_pkg.sv | 7 +
 rtl/reg_bypass_rd.sv | 19 +
 rtl/reg_file_wb.sv | 59 +++++
 tb/tb_reg_file_wb.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/reg_file_wb_pkg.sv
// reg_file_wb_pkg: shared widths and register-number constants for the register file
package reg_file_wb_pkg;
    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA = 5'd31;
endpackage

// File: rtl/reg_bypass_rd.sv
// reg_bypass_rd: one read-port lookup with zero register, staged-write bypass, then array
module reg_bypass_rd
    import reg_file_wb_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic [AW-1:0] ra,
    input  logic          pend_valid,
    input  logic [AW-1:0] pend_addr,
    input  logic [DW-1:0] pend_data,
    input  logic [DW-1:0] mem [2**AW],
    output logic [DW-1:0] rd
);
    always_comb begin
        rd = (ra == AW'(REG_ZERO)) ? '0 :
             (pend_valid && pend_addr == ra) ? pend_data : mem[ra];
    end
endmodule

// File: rtl/reg_file_wb.sv
// reg_file_wb: 32x32 register file with one-entry write-back stage, bypassed reads and debug port
module reg_file_wb
    import reg_file_wb_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          hold,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data,
    output logic          pend_valid
);
    localparam int N = 2**AW;
    logic [DW-1:0] mem_q [N];
    logic [DW-1:0] mem_d [N];
    logic          pend_valid_q, pend_valid_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic [DW-1:0] pend_data_q, pend_data_d;
    // Commit of the old stage and capture of the new write happen on the same edge.
    always_comb begin
        mem_d = mem_q;
        if (!hold && pend_valid_q) mem_d[pend_addr_q] = pend_data_q;
        pend_valid_d = hold ? pend_valid_q : (we && wa != AW'(REG_ZERO));
        pend_addr_d  = hold ? pend_addr_q : wa;
        pend_data_d  = hold ? pend_data_q : wd;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) mem_q[i] <= '0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
        end else begin
            mem_q        <= mem_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
        end
    end
    reg_bypass_rd #(.DW(DW), .AW(AW)) u_rd1 (
        .ra(ra1), .pend_valid(pend_valid_q), .pend_addr(pend_addr_q),
        .pend_data(pend_data_q), .mem(mem_q), .rd(rd1)
    );
    reg_bypass_rd #(.DW(DW), .AW(AW)) u_rd2 (
        .ra(ra2), .pend_valid(pend_valid_q), .pend_addr(pend_addr_q),
        .pend_data(pend_data_q), .mem(mem_q), .rd(rd2)
    );
    assign dbg_data   = (dbg_addr == AW'(REG_ZERO)) ? '0 : mem_q[dbg_addr];
    assign pend_valid = pend_valid_q;
endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: scoreboard bench for reg_file_wb staging, bypass, hold and reset behaviour
module tb_reg_file_wb;
    import reg_file_wb_pkg::*;
    typedef enum int {P_RD1, P_RD2, P_DBG, P_PEND} port_e;
    typedef struct {
        string       tag;
        port_e       port;
        logic [4:0]  addr;
        logic [31:0] exp;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  wa = '0;
    logic [31:0] wd = '0;
    logic        hold = 1'b0;
    logic [4:0]  ra1 = '0;
    logic [4:0]  ra2 = '0;
    logic [31:0] rd1, rd2;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
    logic        pend_valid;
    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    reg_file_wb dut (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .hold(hold),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .pend_valid(pend_valid)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input string tag, input port_e port, input logic [4:0] addr,
                              input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.port = port;
        e.addr = addr;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] got;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ra1 = e.addr;
            ra2 = e.addr;
            dbg_addr = e.addr;
            #1;
            got = (e.port == P_RD1) ? rd1 : (e.port == P_RD2) ? rd2 :
                  (e.port == P_DBG) ? dbg_data : {31'd0, pend_valid};
            check(e.tag, got, e.exp);
        end
    endtask

    task automatic step(input logic w, input logic [4:0] a, input logic [31:0] d, input logic h);
        @(negedge clk);
        we = w;
        wa = a;
        wd = d;
        hold = h;
        @(posedge clk);
        #5;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 5'd5, 32'h55, 1'b0);
        step(1'b1, 5'd6, 32'h66, 1'b0);
        expect_val("pre_rst_rd1_5", P_RD1, 5'd5, 32'h55);
        expect_val("pre_rst_rd1_6", P_RD1, 5'd6, 32'h66);
        expect_val("pre_rst_pend", P_PEND, 5'd0, 32'd1);
        drain();
        #20;
        rst = 1'b1;
        expect_val("rst_pend", P_PEND, 5'd0, 32'd0);
        for (int i = 0; i < 32; i++) begin
            expect_val($sformatf("rst_rd1_%0d", i), P_RD1, 5'(i), 32'd0);
            expect_val($sformatf("rst_rd2_%0d", i), P_RD2, 5'(i), 32'd0);
            expect_val($sformatf("rst_dbg_%0d", i), P_DBG, 5'(i), 32'd0);
        end
        drain();
        #1000;
        @(negedge clk);
        rst = 1'b0;

        step(1'b1, REG_ZERO, 32'hDEADBEEF, 1'b0);
        expect_val("zero_pend", P_PEND, 5'd0, 32'd0);
        expect_val("zero_rd1", P_RD1, 5'd0, 32'd0);
        expect_val("zero_rd2", P_RD2, 5'd0, 32'd0);
        expect_val("zero_dbg", P_DBG, 5'd0, 32'd0);
        drain();

        step(1'b1, 5'd2, 32'h12345678, 1'b0);
        expect_val("byp_rd1", P_RD1, 5'd2, 32'h12345678);
        expect_val("byp_dbg", P_DBG, 5'd2, 32'd0);
        expect_val("byp_pend", P_PEND, 5'd0, 32'd1);
        drain();
        step(1'b0, 5'd0, 32'd0, 1'b0);
        expect_val("commit_dbg", P_DBG, 5'd2, 32'h12345678);
        expect_val("commit_pend", P_PEND, 5'd0, 32'd0);
        expect_val("commit_rd1", P_RD1, 5'd2, 32'h12345678);
        drain();

        for (int k = 0; k < 3; k++) begin
            step(1'b1, 5'd3, 32'(1 << k), 1'b0);
            expect_val($sformatf("b2b_rd2_%0d", k), P_RD2, 5'd3, 32'(1 << k));
            expect_val($sformatf("b2b_dbg_%0d", k), P_DBG, 5'd3, (k == 0) ? 32'd0 : 32'(1 << (k - 1)));
            drain();
        end
        step(1'b0, 5'd0, 32'd0, 1'b0);
        expect_val("b2b_dbg_final", P_DBG, 5'd3, 32'd4);
        expect_val("b2b_rd2_final", P_RD2, 5'd3, 32'd4);
        drain();

        step(1'b1, 5'd10, 32'hAA, 1'b0);
        step(1'b1, 5'd11, 32'hBB, 1'b0);
        expect_val("indep_dbg10", P_DBG, 5'd10, 32'hAA);
        expect_val("indep_rd1_11", P_RD1, 5'd11, 32'hBB);
        expect_val("indep_dbg11", P_DBG, 5'd11, 32'd0);
        expect_val("indep_rd2_10", P_RD2, 5'd10, 32'hAA);
        drain();

        @(negedge clk);
        we = 1'b1;
        wa = 5'd12;
        wd = 32'hC0C0;
        hold = 1'b0;
        expect_val("sameedge_old", P_RD1, 5'd12, 32'd0);
        drain();
        @(posedge clk);
        #5;
        expect_val("sameedge_new", P_RD1, 5'd12, 32'hC0C0);
        drain();

        step(1'b1, REG_RA, 32'd5, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 5'd4, 32'd9, 1'b1);
            expect_val($sformatf("hold_pend_%0d", k), P_PEND, 5'd0, 32'd1);
            expect_val($sformatf("hold_dbg31_%0d", k), P_DBG, REG_RA, 32'd0);
            expect_val($sformatf("hold_rd1_4_%0d", k), P_RD1, 5'd4, 32'd0);
            expect_val($sformatf("hold_rd1_31_%0d", k), P_RD1, REG_RA, 32'd5);
            drain();
        end
        step(1'b1, 5'd4, 32'd9, 1'b0);
        expect_val("unhold_dbg31", P_DBG, REG_RA, 32'd5);
        expect_val("unhold_rd1_4", P_RD1, 5'd4, 32'd9);
        expect_val("unhold_dbg4", P_DBG, 5'd4, 32'd0);
        drain();
        step(1'b0, 5'd0, 32'd0, 1'b0);

        step(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0);
        expect_val("midrst_byp", P_RD1, 5'd7, 32'hA5A5A5A5);
        drain();
        #20;
        we = 1'b0;
        rst = 1'b1;
        #10;
        rst = 1'b0;
        repeat (2) step(1'b0, 5'd0, 32'd0, 1'b0);
        expect_val("midrst_rd1", P_RD1, 5'd7, 32'd0);
        expect_val("midrst_dbg", P_DBG, 5'd7, 32'd0);
        expect_val("midrst_pend", P_PEND, 5'd0, 32'd0);
        expect_val("midrst_clr2", P_DBG, 5'd2, 32'd0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
